uxa_ps2_rxq: RTL and testbench

- Receive queue directly downstream of the PS/2 deserializer (M_uxa_ps2_shfreg).
- Captures each completed byte on the rising edge of the deserializer's frame strobe and buffers it in a small FIFO.
- Presents the buffered bytes to the host-side register interface through a first-word-fall-through read handshake.
- Drives a PS/2 clock-inhibit request when the queue nears full, so the keyboard holds off instead of bytes being lost.

---
 rtl/uxa_ps2_pkg.sv | 15 +
 rtl/uxa_ps2_rxq_if.sv | 34 +++
 rtl/uxa_ps2_sfifo.sv | 60 ++++++
 rtl/uxa_ps2_rxq.sv | 97 +++++++++
 tb/tb_uxa_ps2_rxq.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/uxa_ps2_pkg.sv
// rtl/uxa_ps2_pkg.sv - shared PS/2 constants, byte type and odd-parity check
package uxa_ps2_pkg;

    localparam int PS2_BYTE_W       = 8;
    localparam int PS2_RXQ_DEPTH    = 16;
    localparam int PS2_RXQ_HEADROOM = 2;

    typedef logic [PS2_BYTE_W-1:0] ps2_byte_t;

    // PS/2 frames carry odd parity over the data byte plus the parity bit.
    function automatic logic ps2_odd_parity_ok(input ps2_byte_t d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/uxa_ps2_rxq_if.sv
// rtl/uxa_ps2_rxq_if.sv - deserializer/host side bundle of the PS/2 receive queue
// parity_i/perr_o exist only when UXA_PS2_RXQ_PARITY_EN is defined.
interface uxa_ps2_rxq_if #(
    parameter int DEPTH = 16
);
    import uxa_ps2_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    ps2_byte_t     d_i;
    logic          frame_i;
    logic          rd_i;
    logic          clr_i;
    ps2_byte_t     data_o;
    logic          valid_o;
    logic [CW-1:0] count_o;
    logic          ovf_o;
    logic          inhibit_o;
`ifdef UXA_PS2_RXQ_PARITY_EN
    logic          parity_i;
    logic          perr_o;

    modport master (output d_i, frame_i, rd_i, clr_i, parity_i,
                    input  data_o, valid_o, count_o, ovf_o, inhibit_o, perr_o);
    modport slave  (input  d_i, frame_i, rd_i, clr_i, parity_i,
                    output data_o, valid_o, count_o, ovf_o, inhibit_o, perr_o);
`else
    modport master (output d_i, frame_i, rd_i, clr_i,
                    input  data_o, valid_o, count_o, ovf_o, inhibit_o);
    modport slave  (input  d_i, frame_i, rd_i, clr_i,
                    output data_o, valid_o, count_o, ovf_o, inhibit_o);
`endif

endinterface

// File: rtl/uxa_ps2_sfifo.sv
// rtl/uxa_ps2_sfifo.sv - generic synchronous FWFT FIFO with push/pop/clr, count, full, empty
module uxa_ps2_sfifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [W-1:0]               din_i,
    input  logic                       pop_i,
    input  logic                       clr_i,
    output logic [W-1:0]               dout_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       push_ok_o,
    output logic                       pop_ok_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [W-1:0]  mem_q [DEPTH];

    assign empty_o   = (wr_q == rd_q);
    assign full_o    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop_ok_o  = pop_i & ~empty_o & ~clr_i;
    // A pop in the same cycle frees the slot the push lands in.
    assign push_ok_o = push_i & ~clr_i & (~full_o | pop_ok_o);
    assign count_o   = wr_q - rd_q;
    assign dout_o    = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (clr_i) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (push_ok_o) wr_d = wr_q + PW'(1);
            if (pop_ok_o)  rd_d = rd_q + PW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok_o) mem_q[wr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/uxa_ps2_rxq.sv
// rtl/uxa_ps2_rxq.sv - PS/2 receive queue: frame edge capture, FIFO, overflow and clock-inhibit
// Optional parity screening with sticky perr_o under UXA_PS2_RXQ_PARITY_EN.
module uxa_ps2_rxq
    import uxa_ps2_pkg::*;
#(
    parameter int DEPTH    = PS2_RXQ_DEPTH,
    parameter int HEADROOM = PS2_RXQ_HEADROOM
) (
    input  logic         sys_clk_i,
    input  logic         reset_ni,
    uxa_ps2_rxq_if.slave q
);
    localparam int            CW     = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] THRESH = CW'(DEPTH - HEADROOM);

    logic          frame_q;
    logic          ovf_q, ovf_d;
    logic          inhibit_q, inhibit_d;
    logic          push_evt, byte_ok, fifo_push;
    logic          push_ok, pop_ok, full, empty;
    logic [CW-1:0] count, count_d;
    ps2_byte_t     head;

    assign push_evt = q.frame_i & ~frame_q;

`ifdef UXA_PS2_RXQ_PARITY_EN
    logic perr_q, perr_d;
    assign byte_ok  = ps2_odd_parity_ok(q.d_i, q.parity_i);
    assign q.perr_o = perr_q;
`else
    assign byte_ok = 1'b1;
`endif

    assign fifo_push = push_evt & byte_ok;

    uxa_ps2_sfifo #(
        .W     (PS2_BYTE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (sys_clk_i),
        .rst_ni    (reset_ni),
        .push_i    (fifo_push),
        .din_i     (q.d_i),
        .pop_i     (q.rd_i),
        .clr_i     (q.clr_i),
        .dout_o    (head),
        .count_o   (count),
        .full_o    (full),
        .empty_o   (empty),
        .push_ok_o (push_ok),
        .pop_ok_o  (pop_ok)
    );

    // Inhibit is registered from the post-edge occupancy so it moves with count_o.
    always_comb begin
        count_d = q.clr_i ? '0 : count + CW'(push_ok) - CW'(pop_ok);
        inhibit_d = (count_d >= THRESH);
        ovf_d = ovf_q;
        if (q.clr_i)
            ovf_d = 1'b0;
        else if (fifo_push && full && !pop_ok)
            ovf_d = 1'b1;
`ifdef UXA_PS2_RXQ_PARITY_EN
        perr_d = perr_q;
        if (q.clr_i)
            perr_d = 1'b0;
        else if (push_evt && !byte_ok)
            perr_d = 1'b1;
`endif
    end

    // frame_q resets high so a frame already asserted at release is not taken as a new byte.
    always_ff @(posedge sys_clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            frame_q   <= 1'b1;
            ovf_q     <= 1'b0;
            inhibit_q <= 1'b0;
`ifdef UXA_PS2_RXQ_PARITY_EN
            perr_q    <= 1'b0;
`endif
        end else begin
            frame_q   <= q.frame_i;
            ovf_q     <= ovf_d;
            inhibit_q <= inhibit_d;
`ifdef UXA_PS2_RXQ_PARITY_EN
            perr_q    <= perr_d;
`endif
        end
    end

    assign q.data_o    = head;
    assign q.valid_o   = ~empty;
    assign q.count_o   = count;
    assign q.ovf_o     = ovf_q;
    assign q.inhibit_o = inhibit_q;

endmodule

// File: tb/tb_uxa_ps2_rxq.sv
// tb/tb_uxa_ps2_rxq.sv - scoreboard bench for uxa_ps2_rxq (directed plus random traffic)
`timescale 1ns/1ps
module tb_uxa_ps2_rxq;
    import uxa_ps2_pkg::*;

    localparam int DEPTH    = 16;
    localparam int HEADROOM = 2;

    logic sys_clk_i = 1'b0;
    logic reset_ni  = 1'b0;
    always #5 sys_clk_i = ~sys_clk_i;

    uxa_ps2_rxq_if #(.DEPTH(DEPTH)) bus ();

    uxa_ps2_rxq #(.DEPTH(DEPTH), .HEADROOM(HEADROOM)) dut (
        .sys_clk_i (sys_clk_i),
        .reset_ni  (reset_ni),
        .q         (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] model_q[$];
    logic [7:0] sb_q[$];
    bit         m_frame_prev = 1'b1;
    bit         m_ovf        = 1'b0;
    bit         m_perr       = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a byte queue of capacity DEPTH; a same-cycle pop frees room first.
    task automatic model_step();
        bit edge_e, good;
        edge_e       = bus.frame_i && !m_frame_prev;
        m_frame_prev = bus.frame_i;
        good         = 1'b1;
`ifdef UXA_PS2_RXQ_PARITY_EN
        good = ($countones({bus.d_i, bus.parity_i}) % 2) == 1;
`endif
        if (bus.clr_i) begin
            model_q.delete();
            m_ovf  = 1'b0;
            m_perr = 1'b0;
        end else begin
            if (bus.rd_i && model_q.size() > 0) void'(model_q.pop_front());
            if (edge_e) begin
                if (!good)
                    m_perr = 1'b1;
                else if (model_q.size() >= DEPTH)
                    m_ovf = 1'b1;
                else begin
                    model_q.push_back(bus.d_i);
                    sb_q.push_back(bus.d_i);
                end
            end
        end
    endtask

    task automatic cyc(input logic f, input logic [7:0] d, input logic rd,
                       input logic clr, input bit pbad = 1'b0);
        bus.frame_i = f;
        bus.d_i     = d;
        bus.rd_i    = rd;
        bus.clr_i   = clr;
`ifdef UXA_PS2_RXQ_PARITY_EN
        bus.parity_i = (($countones(d) % 2) == 0) ^ pbad;
`endif
        @(posedge sys_clk_i);
        model_step();
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        cyc(1'b1, b, 1'b0, 1'b0);
        cyc(1'b0, b, 1'b0, 1'b0);
    endtask

    task automatic pop_one();
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    // Monitor: mid-cycle, compare state and retire scoreboard entries on real pops.
    always @(negedge sys_clk_i) begin
        chk("count", int'(bus.count_o), model_q.size());
        chk("valid", int'(bus.valid_o), int'(model_q.size() != 0));
        chk("ovf", int'(bus.ovf_o), int'(m_ovf));
        chk("inhibit", int'(bus.inhibit_o), int'(model_q.size() >= DEPTH - HEADROOM));
`ifdef UXA_PS2_RXQ_PARITY_EN
        chk("perr", int'(bus.perr_o), int'(m_perr));
`endif
        if (model_q.size() == 0) chk("data_empty", int'(bus.data_o), 0);
        if (reset_ni && bus.clr_i) begin
            sb_q.delete();
        end else if (reset_ni && bus.rd_i && bus.valid_o) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_pop: DUT offered 0x%0h with no byte expected", bus.data_o);
            end else begin
                chk("sb_pop", int'(bus.data_o), int'(sb_q.pop_front()));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.frame_i = 1'b1;
        bus.d_i     = 8'h00;
        bus.rd_i    = 1'b0;
        bus.clr_i   = 1'b0;
`ifdef UXA_PS2_RXQ_PARITY_EN
        bus.parity_i = 1'b0;
`endif
        reset_ni = 1'b0;
        repeat (3) @(posedge sys_clk_i);
        #1;
        reset_ni = 1'b1;

        // Frame already high at release must not push.
        repeat (10) cyc(1'b1, 8'h5A, 1'b0, 1'b0);
        chk("no_push_release", int'(bus.count_o), 0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 8'h64, 1'b0, 1'b0);
        chk("first_data", int'(bus.data_o), 8'h64);
        chk("first_valid", int'(bus.valid_o), 1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        chk("three_count", int'(bus.count_o), 3);
        repeat (3) pop_one();
        chk("three_drained", int'(bus.valid_o), 0);
        pop_one();

        for (int i = 0; i < 14; i++) begin
            if (i == 13) chk("inhibit_below", int'(bus.inhibit_o), 0);
            push_byte(8'(8'h40 + i));
        end
        chk("inhibit_at_thr", int'(bus.inhibit_o), 1);
        pop_one();
        chk("inhibit_release", int'(bus.inhibit_o), 0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        for (int i = 0; i < 17; i++) push_byte(8'(i));
        chk("full_count", int'(bus.count_o), 16);
        chk("full_ovf", int'(bus.ovf_o), 1);
        chk("full_head", int'(bus.data_o), 8'h00);
        repeat (16) pop_one();
        chk("drained_ovf_sticky", int'(bus.ovf_o), 1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_ovf", int'(bus.ovf_o), 0);

        for (int i = 0; i < 16; i++) push_byte(8'(8'h80 + i));
        cyc(1'b1, 8'hEE, 1'b1, 1'b0);
        chk("pushpop_count", int'(bus.count_o), 16);
        chk("pushpop_ovf", int'(bus.ovf_o), 0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (15) pop_one();
        chk("pushpop_last", int'(bus.data_o), 8'hEE);
        cyc(1'b1, 8'h77, 1'b1, 1'b1);
        chk("clr_count", int'(bus.count_o), 0);
        chk("clr_valid", int'(bus.valid_o), 0);
        cyc(1'b1, 8'h77, 1'b0, 1'b0);
        chk("clr_frame_held", int'(bus.count_o), 0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("empty_rd_noop", int'(bus.count_o), 0);

`ifdef UXA_PS2_RXQ_PARITY_EN
        cyc(1'b1, 8'h64, 1'b0, 1'b0, 1'b1);
        chk("perr_set", int'(bus.perr_o), 1);
        chk("perr_dropped", int'(bus.count_o), 0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 8'h64, 1'b0, 1'b0, 1'b0);
        chk("parity_ok_stored", int'(bus.data_o), 8'h64);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("perr_clr", int'(bus.perr_o), 0);
`endif

        for (int i = 0; i < 500; i++) begin
            int rd_pct;
            rd_pct = (i < 250) ? 12 : 60;
            cyc(1'($urandom_range(0, 1)), 8'($urandom),
                1'($urandom_range(0, 99) < rd_pct),
                1'($urandom_range(0, 99) < 2),
                1'($urandom_range(0, 99) < 6));
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (2) @(posedge sys_clk_i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
